// File: rtl/pc_gen_pkg.sv
// Shared constants and the next-PC source encoding for the fetch PC generator.
package pc_gen_pkg;
   localparam int unsigned DEF_ADDR_W    = 32;
   localparam logic [63:0] DEF_RESET_VEC = 64'h0;
   localparam int unsigned DEF_INC       = 4;

   typedef enum logic [1:0] {
      HOLD,
      REDIRECT,
      RAS,
      SEQ
   } pc_src_e;
endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push, pop and replace-top; the oldest entry is overwritten when full.
module ras_stack #(
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     replace,
   input  logic [ADDR_W-1:0]        push_data,
   output logic [ADDR_W-1:0]        top_data,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  top_ptr;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == CNT_W'(DEPTH)) ? c : c + 1'b1;
   endfunction

   assign top_data = mem[top_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         top_ptr <= '0;
         count   <= '0;
      end else if (push) begin
         top_ptr <= top_ptr + 1'b1;
         count   <= sat_inc(count);
      end else if (pop) begin
         top_ptr <= top_ptr - 1'b1;
         count   <= count - 1'b1;
      end
   end

   // Entry contents carry no reset; the pointer and count alone define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[top_ptr + 1'b1] <= push_data;
      end else if (replace) begin
         mem[top_ptr] <= push_data;
      end
   end
endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: stall, redirect, return-stack pop or sequential increment, registered.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int              ADDR_W    = DEF_ADDR_W,
   parameter int              RAS_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
   parameter int unsigned     INC       = DEF_INC
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        pc_we,
   input  logic                        redirect_valid,
   input  logic [ADDR_W-1:0]           redirect_target,
   input  logic                        call,
   input  logic                        ret,
   output logic [ADDR_W-1:0]           pc_out,
   output logic [$clog2(RAS_DEPTH):0]  ras_count,
   output logic                        ras_underflow
);
   pc_src_e           src;
   logic [ADDR_W-1:0] seq_pc;
   logic [ADDR_W-1:0] ras_top;
   logic [ADDR_W-1:0] next_pc;
   logic              ras_push;
   logic              ras_pop;
   logic              ras_replace;
   logic              underflow_next;
   logic              ras_hit;

   assign seq_pc  = pc_out + ADDR_W'(INC);
   assign ras_hit = (ras_count != '0);

   always_comb begin
      src            = HOLD;
      ras_push       = 1'b0;
      ras_pop        = 1'b0;
      ras_replace    = 1'b0;
      underflow_next = 1'b0;
      if (pc_we) begin
         if (redirect_valid)      src = REDIRECT;
         else if (ret && ras_hit) src = RAS;
         else                     src = SEQ;

         // call+ret on an empty stack degrades to a plain push with no underflow.
         if (call && ret && ras_hit) ras_replace    = 1'b1;
         else if (call)              ras_push       = 1'b1;
         else if (ret && ras_hit)    ras_pop        = 1'b1;
         else if (ret)               underflow_next = 1'b1;
      end
   end

   always_comb begin
      next_pc = pc_out;
      case (src)
         HOLD:     next_pc = pc_out;
         REDIRECT: next_pc = redirect_target;
         RAS:      next_pc = ras_top;
         SEQ:      next_pc = seq_pc;
         default:  next_pc = pc_out;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_out        <= RESET_VEC;
         ras_underflow <= 1'b0;
      end else begin
         pc_out        <= next_pc;
         ras_underflow <= underflow_next;
      end
   end

   ras_stack #(
      .ADDR_W (ADDR_W),
      .DEPTH  (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .reset     (reset),
      .push      (ras_push),
      .pop       (ras_pop),
      .replace   (ras_replace),
      .push_data (seq_pc),
      .top_data  (ras_top),
      .count     (ras_count)
   );
endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen with hand-computed expected PCs, stack depths and underflow pulses.
module tb_pc_gen;
   logic        clk;
   logic        reset;
   logic        pc_we;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        call;
   logic        ret;
   logic [31:0] pc_out;
   logic [2:0]  ras_count;
   logic        ras_underflow;

   int checks = 0;
   int errors = 0;

   pc_gen dut (
      .clk             (clk),
      .reset           (reset),
      .pc_we           (pc_we),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .call            (call),
      .ret             (ret),
      .pc_out          (pc_out),
      .ras_count       (ras_count),
      .ras_underflow   (ras_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic we, input logic rv, input logic [31:0] tgt,
                        input logic c, input logic r);
      pc_we = we; redirect_valid = rv; redirect_target = tgt; call = c; ret = r;
   endtask

   task automatic chk(input string tag, input logic [31:0] pc, input logic [2:0] cnt,
                      input logic uf);
      check({tag, "_pc"}, pc_out, pc);
      check({tag, "_cnt"}, {29'd0, ras_count}, {29'd0, cnt});
      check({tag, "_uf"}, {31'd0, ras_underflow}, {31'd0, uf});
   endtask

   initial begin
      reset = 1'b1;
      drive(1, 0, 32'h0, 0, 0);
      step();
      chk("reset", 32'h0, 3'd0, 1'b0);
      reset = 1'b0;

      // Free run from the reset vector
      step(); chk("seq1", 32'h4, 3'd0, 1'b0);
      step(); chk("seq2", 32'h8, 3'd0, 1'b0);
      step(); chk("seq3", 32'hC, 3'd0, 1'b0);
      step(); chk("seq4", 32'h10, 3'd0, 1'b0);

      // Stall with every request asserted
      drive(0, 1, 32'h80, 1, 1);
      step(); chk("stall1", 32'h10, 3'd0, 1'b0);
      step(); chk("stall2", 32'h10, 3'd0, 1'b0);
      drive(1, 0, 32'h0, 0, 0);
      step(); chk("unstall", 32'h14, 3'd0, 1'b0);

      // Call / return
      drive(1, 1, 32'h20, 0, 0);
      step(); chk("redir20", 32'h20, 3'd0, 1'b0);
      drive(1, 1, 32'h100, 1, 0);
      step(); chk("call", 32'h100, 3'd1, 1'b0);
      drive(1, 0, 32'h0, 0, 0);
      step(); chk("body1", 32'h104, 3'd1, 1'b0);
      step(); chk("body2", 32'h108, 3'd1, 1'b0);
      drive(1, 0, 32'h0, 0, 1);
      step(); chk("ret", 32'h24, 3'd0, 1'b0);

      // Overflow: five nested calls into a four-deep stack
      drive(1, 1, 32'h0, 0, 0);
      step(); chk("redir0", 32'h0, 3'd0, 1'b0);
      drive(1, 1, 32'h10, 1, 0);  step(); chk("ov_c1", 32'h10, 3'd1, 1'b0);
      drive(1, 1, 32'h20, 1, 0);  step(); chk("ov_c2", 32'h20, 3'd2, 1'b0);
      drive(1, 1, 32'h30, 1, 0);  step(); chk("ov_c3", 32'h30, 3'd3, 1'b0);
      drive(1, 1, 32'h40, 1, 0);  step(); chk("ov_c4", 32'h40, 3'd4, 1'b0);
      drive(1, 1, 32'h200, 1, 0); step(); chk("ov_c5", 32'h200, 3'd4, 1'b0);
      drive(1, 0, 32'h0, 0, 1);
      step(); chk("ov_r1", 32'h44, 3'd3, 1'b0);
      step(); chk("ov_r2", 32'h34, 3'd2, 1'b0);
      step(); chk("ov_r3", 32'h24, 3'd1, 1'b0);
      step(); chk("ov_r4", 32'h14, 3'd0, 1'b0);
      step(); chk("ov_r5", 32'h18, 3'd0, 1'b1);
      drive(1, 0, 32'h0, 0, 0);
      step(); chk("uf_end", 32'h1C, 3'd0, 1'b0);

      // call+ret together: empty stack pushes, non-empty replaces the top
      drive(1, 0, 32'h0, 1, 1);
      step(); chk("cr_empty", 32'h20, 3'd1, 1'b0);
      step(); chk("cr_repl", 32'h20, 3'd1, 1'b0);
      drive(1, 0, 32'h0, 0, 1);
      step(); chk("cr_ret", 32'h24, 3'd0, 1'b0);

      // ret with redirect still pops
      drive(1, 1, 32'h500, 1, 0);
      step(); chk("rr_call", 32'h500, 3'd1, 1'b0);
      drive(1, 1, 32'h600, 0, 1);
      step(); chk("rr_ret", 32'h600, 3'd0, 1'b0);

      // Address-space wrap
      drive(1, 1, 32'hFFFF_FFFC, 0, 0);
      step(); chk("wrap_pre", 32'hFFFF_FFFC, 3'd0, 1'b0);
      drive(1, 0, 32'h0, 0, 0);
      step(); chk("wrap", 32'h0, 3'd0, 1'b0);

      // Asynchronous reset between edges while a call is pending
      drive(1, 1, 32'h40, 1, 0);
      step(); chk("pre_rst", 32'h40, 3'd1, 1'b0);
      drive(1, 1, 32'h80, 1, 0);
      #2 reset = 1'b1;
      #1 chk("async_rst", 32'h0, 3'd0, 1'b0);
      step(); chk("rst_hold", 32'h0, 3'd0, 1'b0);
      reset = 1'b0;
      drive(1, 0, 32'h0, 0, 0);
      step(); chk("post_rst", 32'h4, 3'd0, 1'b0);
      drive(1, 0, 32'h0, 0, 1);
      step(); chk("post_rst_ret", 32'h8, 3'd0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter ADDR_W, default 32: PC and target width in bits.
REQ-002 Parameter RAS_DEPTH, default 4: return-address-stack entries; power of two, at least 2.
REQ-003 Parameter RESET_VEC, default 0: PC value loaded on reset.
REQ-004 Parameter INC, default 4: sequential PC increment.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 pc_we  in  1  1 = PC may advance; 0 = stall, all state held.
REQ-008 redirect_valid  in  1  branch/jump taken this cycle.
REQ-009 redirect_target  in  ADDR_W  destination when redirect_valid=1.
REQ-010 call  in  1  current instruction is a call (push return address).
REQ-011 ret  in  1  current instruction is a return (pop return address).
REQ-012 pc_out  out  ADDR_W  registered current PC.
REQ-013 ras_count  out  clog2(RAS_DEPTH)+1  number of valid RAS entries.
REQ-014 ras_underflow  out  1  registered one-cycle pulse: ret issued with an empty RAS.

Function
REQ-015 The next PC, priority high to low, SHALL be:
- pc_we=0: hold.
- redirect_valid=1: redirect_target.
- ret=1 with ras_count>0: RAS top.
- otherwise: pc_out+INC.
REQ-016 All arithmetic SHALL be modulo 2^ADDR_W; pc_out+INC wraps silently at the top of the address space.
REQ-017 Every update SHALL take effect at the clk edge following the request; latency 1 cycle; pc_out never changes combinationally.
REQ-018 call=1 with pc_we=1 SHALL push pc_out+INC; the call target arrives via redirect_valid/redirect_target in the same cycle.
REQ-019 Push when ras_count=RAS_DEPTH SHALL overwrite the oldest entry (circular buffer); ras_count stays at RAS_DEPTH.
REQ-020 ret=1 with pc_we=1, redirect_valid=0 and ras_count>0 SHALL pop: next PC = top entry, ras_count decremented.
REQ-021 ret=1 with pc_we=1 and ras_count=0 SHALL take the sequential PC, leave the RAS unchanged, and pulse ras_underflow high for exactly one cycle.
REQ-022 ret=1 with redirect_valid=1 SHALL still pop the RAS, but redirect_target SHALL supply the next PC.
REQ-023 call=1 and ret=1 together SHALL replace the top entry with pc_out+INC, leaving ras_count unchanged. The next PC is the old top, or redirect_target if redirect_valid=1. With an empty RAS this case SHALL push, and SHALL NOT flag underflow.
REQ-024 While pc_we=0, call, ret and redirect_valid SHALL be ignored; RAS, ras_count and pc_out hold, and ras_underflow is 0.
REQ-025 ras_underflow SHALL be 0 in every cycle not covered by REQ-021.

Reset
REQ-026 Reset assertion SHALL immediately force pc_out=RESET_VEC, ras_count=0 and ras_underflow=0, independent of clk.
REQ-027 Reset SHALL clear the RAS pointer; entry contents need not be cleared.
REQ-028 Reset asserted mid-operation, including during a stall or a simultaneous call/ret, SHALL discard the pending update.
REQ-029 Normal operation SHALL resume on the first rising clk edge after reset deasserts.

Structure
REQ-030 A shared package SHALL hold the default ADDR_W, RESET_VEC and INC constants and a next-PC-source enumeration: HOLD, REDIRECT, RAS, SEQ.
REQ-031 The RAS SHALL be a sub-module ras_stack, containing:
- a storage array;
- a top pointer;
- a count with circular overwrite;
- push/pop/replace controls.
REQ-032 Next-PC selection and the PC register SHALL reside in pc_gen.

Verification
REQ-033 Reset then free-run: 3 cycles with pc_we=1 and no requests -> pc_out = 0x0, 0x4, 0x8, 0xC.
REQ-034 Stall: pc_out=0x10, pc_we=0 for 2 cycles with redirect_valid=1, target 0x80 -> pc_out holds 0x10; after pc_we=1 with no requests -> 0x14.
REQ-035 Call/return: at 0x20, call plus redirect to 0x100; 2 sequential cycles; then ret -> pc_out = 0x100, 0x104, 0x108, 0x24; ras_count goes 1 then 0.
REQ-036 Overflow: RAS_DEPTH=4; 5 calls from 0x0, 0x10, 0x20, 0x30, 0x40 -> ras_count=4; 4 rets return 0x44, 0x34, 0x24, 0x14; a 5th ret -> sequential PC and ras_underflow pulses once.
REQ-037 Wrap: ADDR_W=32 with pc_out=0xFFFFFFFC -> next pc_out=0x0.
REQ-038 Async reset mid-call: reset asserted between clk edges while call=1 -> pc_out=RESET_VEC and ras_count=0 before the next edge; no push recorded.
